// File: rtl/horner_pkg.sv
// rtl/horner_pkg.sv - shared state encoding and default widths for the Horner sequencer
package horner_pkg;

  localparam int W_DEF  = 32;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAITC = 3'd2,
    ADD   = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/horner_mac_stage.sv
// rtl/horner_mac_stage.sv - registered multiply stage followed by registered add stage
module horner_mac_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mul_en_i,
  input  logic         add_en_i,
  input  logic         init_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] prod_q, prod_d;
  logic [W-1:0] coef_q;
  logic [W-1:0] sum_q, sum_d;

  // Product keeps only the low W bits; the accumulator feeds back as the multiplicand.
  assign prod_d = sum_q * x_i;
  assign sum_d  = init_i ? c_i : prod_q + coef_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      coef_q <= '0;
    end else if (mul_en_i) begin
      prod_q <= prod_d;
      coef_q <= c_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/horner_seq.sv
// rtl/horner_seq.sv - Horner-rule polynomial sequencer with valid/ready coefficient and result ports
module horner_seq
  import horner_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  x_in,
  input  logic [DW-1:0] degree,
  output logic          busy,
  input  logic          coef_valid,
  input  logic [W-1:0]  coef_data,
  output logic          coef_ready,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  input  logic          res_ready
);

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  acc;
  logic          coef_hs;
  logic          mul_en, add_en, init;

  assign coef_ready = (state_q == LOAD) || (state_q == WAITC);
  assign coef_hs    = coef_ready && coef_valid;
  assign busy       = (state_q != IDLE);
  assign res_valid  = (state_q == OUT);
  assign res_data   = acc;

  assign mul_en = (state_q == WAITC) && coef_valid;
  assign init   = (state_q == LOAD);
  assign add_en = ((state_q == LOAD) && coef_valid) || (state_q == ADD);

  horner_mac_stage #(.W(W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .mul_en_i (mul_en),
    .add_en_i (add_en),
    .init_i   (init),
    .x_i      (x_q),
    .c_i      (coef_data),
    .sum_o    (acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          cnt_d   = degree;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (coef_hs) state_d = (cnt_q == '0) ? OUT : WAITC;
      end
      WAITC: begin
        if (coef_hs) state_d = ADD;
      end
      ADD: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == DW'(1)) ? OUT : WAITC;
      end
      OUT: begin
        // A start arriving together with res_ready is dropped, not queued.
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

endmodule

// File: tb/tb_horner_seq.sv
// tb/tb_horner_seq.sv - randomized self-checking bench for horner_seq against a power-sum model
module tb_horner_seq;

  localparam int W  = 32;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  x_in;
  logic [DW-1:0] degree;
  logic          busy;
  logic          coef_valid;
  logic [W-1:0]  coef_data;
  logic          coef_ready;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] cf [0:255];

  always #5 clk = ~clk;

  horner_seq #(.W(W), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .degree     (degree),
    .busy       (busy),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // p(x) as a sum of a_k * x^k, wrapping at W bits
  function automatic logic [W-1:0] ref_poly(input logic [W-1:0] x, input int deg);
    logic [W-1:0] s;
    logic [W-1:0] p;
    s = '0;
    for (int i = 0; i <= deg; i++) begin
      p = 1;
      for (int k = 0; k < deg - i; k++) p = p * x;
      s = s + cf[i] * p;
    end
    return s;
  endfunction

  // Producer offers coefficient i 'gap' cycles after the previous handshake. The
  // sequencer wants a_N in cycle 1, a_(N-1) the cycle after, then one every other cycle.
  task automatic do_eval(input logic [W-1:0] x, input int deg, input int gap,
                         input int hold, input bit noise);
    int c, i, want, avail, res_cyc;
    bit exp_rdy, hs;
    logic [W-1:0] exp_res;
    exp_res    = ref_poly(x, deg);
    start      = 1'b1;
    x_in       = x;
    degree     = DW'(deg);
    coef_valid = 1'b0;
    res_ready  = 1'b0;
    @(posedge clk); #1;
    start   = 1'b0;
    x_in    = $urandom;
    degree  = DW'($urandom);
    c       = 1;
    i       = 0;
    want    = 1;
    avail   = 1 + gap;
    res_cyc = -1;
    while (res_cyc < 0 || c < res_cyc) begin
      if (c > 5000) begin
        check("timeout", 1, 0);
        return;
      end
      exp_rdy    = (i <= deg) && (c >= want);
      coef_valid = (i <= deg) && (c >= avail);
      coef_data  = coef_valid ? cf[i] : $urandom;
      hs         = exp_rdy && coef_valid;
      check("coef_ready", W'(coef_ready), W'(exp_rdy));
      check("busy_run", W'(busy), 1);
      check("res_valid_early", W'(res_valid), 0);
      if (noise) start = 1'($urandom_range(0, 1));
      if (hs) begin
        if (i == deg) res_cyc = (deg == 0) ? c + 1 : c + 2;
        want  = (i == 0) ? c + 1 : c + 2;
        avail = c + 1 + gap;
        i++;
      end
      @(posedge clk); #1;
      c++;
    end
    coef_valid = 1'b0;
    check("res_valid", W'(res_valid), 1);
    check("res_data", res_data, exp_res);
    check("coef_ready_out", W'(coef_ready), 0);
    for (int h = 0; h < hold; h++) begin
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("res_valid_hold", W'(res_valid), 1);
      check("res_data_hold", res_data, exp_res);
    end
    res_ready = 1'b1;
    start     = noise;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
    check("res_valid_drop", W'(res_valid), 0);
    check("busy_idle", W'(busy), 0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    x_in       = '0;
    degree     = '0;
    coef_valid = 1'b0;
    coef_data  = '0;
    res_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_coef_ready", W'(coef_ready), 0);
    check("rst_res_valid", W'(res_valid), 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    cf[0] = 32'h2A;
    do_eval(32'd7, 0, 0, 0, 1'b0);

    cf[0] = 2; cf[1] = 0; cf[2] = 1;
    do_eval(32'd3, 2, 0, 0, 1'b0);

    cf[0] = 1; cf[1] = 0; cf[2] = 0;
    do_eval(32'h0001_0000, 2, 0, 0, 1'b0);
    cf[0] = 1; cf[1] = 1;
    do_eval(32'hFFFF_FFFF, 1, 0, 1, 1'b0);

    for (int k = 0; k < 4; k++) cf[k] = 1;
    do_eval(32'd2, 3, 3, 5, 1'b1);

    // Abort a degree-4 run while it sits in the add stage.
    for (int k = 0; k < 5; k++) cf[k] = k + 1;
    start = 1'b1; x_in = 32'd3; degree = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; coef_valid = 1'b1; coef_data = cf[0];
    @(posedge clk); #1;
    coef_data = cf[1];
    @(posedge clk); #1;
    coef_valid = 1'b0;
    check("add_coef_ready", W'(coef_ready), 0);
    check("add_busy", W'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", W'(busy), 0);
    check("abort_coef_ready", W'(coef_ready), 0);
    check("abort_res_valid", W'(res_valid), 0);
    check("abort_res_data", res_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_abort_res_valid", W'(res_valid), 0);
      check("post_abort_busy", W'(busy), 0);
    end
    cf[0] = 1; cf[1] = 0; cf[2] = 1;
    do_eval(32'd2, 2, 0, 0, 1'b0);

    for (int k = 0; k < 4; k++) cf[k] = $urandom;
    do_eval($urandom, 3, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) cf[k] = $urandom;
    do_eval($urandom, 2, 0, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int d;
      d = $urandom_range(0, 6);
      for (int k = 0; k <= d; k++) cf[k] = $urandom;
      do_eval($urandom, d, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 256; k++) cf[k] = $urandom;
    do_eval($urandom, 255, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
